// File: rtl/io_seq_checker.sv
// Output-port monitor: checks strobed words against base + k*step, counts words,
// errors and run cycles, and reports pass/fail with cycle-budget timeout and overrun.
module io_seq_checker #(
    parameter int WIDTH          = 16,
    parameter int EXPECT_OUTPUTS = 16,
    parameter int MAX_CYCLES     = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seq_base,
    input  logic [WIDTH-1:0] seq_step,
    input  logic             strobe,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_data,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXPECT_OUTPUTS);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
    localparam bit               TMO_EN = (MAX_CYCLES != 0);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] expected, expected_nxt;
    logic [WIDTH-1:0] step, step_nxt;
    logic [WIDTH-1:0] first_err_data_nxt;
    logic [CNT_W-1:0] count_nxt, err_nxt, cycles_nxt, first_err_idx_nxt;
    logic             timeout_nxt, overrun_nxt;
    logic             mismatch, complete;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt          = state;
        expected_nxt       = expected;
        step_nxt           = step;
        count_nxt          = count;
        err_nxt            = err_count;
        cycles_nxt         = cycles;
        first_err_idx_nxt  = first_err_idx;
        first_err_data_nxt = first_err_data;
        timeout_nxt        = timeout;
        overrun_nxt        = overrun;
        mismatch           = 1'b0;
        complete           = 1'b0;

        if (start) begin
            state_nxt          = RUN;
            expected_nxt       = seq_base;
            step_nxt           = seq_step;
            count_nxt          = '0;
            err_nxt            = '0;
            cycles_nxt         = '0;
            first_err_idx_nxt  = '0;
            first_err_data_nxt = '0;
            timeout_nxt        = 1'b0;
            overrun_nxt        = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cycles_nxt = sat_inc(cycles);
                    if (strobe) begin
                        mismatch     = (data != expected);
                        count_nxt    = count + CNT_W'(1);
                        expected_nxt = expected + step;
                        if (mismatch) begin
                            err_nxt = sat_inc(err_count);
                            // err_count saturates, so zero reliably means "no error yet"
                            if (err_count == '0) begin
                                first_err_idx_nxt  = count;
                                first_err_data_nxt = data;
                            end
                        end
                        complete = (count_nxt == EXP_C);
                    end
                    if (complete) begin
                        state_nxt = (err_nxt == '0) ? PASS : FAIL;
                    end else if (TMO_EN && cycles_nxt == MAX_C) begin
                        state_nxt   = FAIL;
                        timeout_nxt = 1'b1;
                    end
                end
                PASS, FAIL: begin
                    if (strobe) begin
                        overrun_nxt = 1'b1;
                        state_nxt   = FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            expected       <= '0;
            step           <= '0;
            count          <= '0;
            err_count      <= '0;
            cycles         <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            expected       <= expected_nxt;
            step           <= step_nxt;
            count          <= count_nxt;
            err_count      <= err_nxt;
            cycles         <= cycles_nxt;
            first_err_idx  <= first_err_idx_nxt;
            first_err_data <= first_err_data_nxt;
            timeout        <= timeout_nxt;
            overrun        <= overrun_nxt;
            busy           <= (state_nxt == RUN);
            done           <= (state_nxt == PASS) || (state_nxt == FAIL);
            pass           <= (state_nxt == PASS);
        end
    end

endmodule

// File: tb/tb_io_seq_checker.sv
// Bench for io_seq_checker: scenario table, hand-written corner sequences and
// randomized runs checked against a position-based reference model.
module tb_io_seq_checker;

    localparam int W    = 16;
    localparam int N    = 16;
    localparam int MAXC = 20;
    localparam int CW   = 16;
    localparam int RLEN = 30;

    logic          clk = 1'b0;
    logic          reset, start, strobe;
    logic [W-1:0]  seq_base, seq_step, data;
    logic          busy, done, pass, timeout, overrun;
    logic [CW-1:0] count, err_count, cycles, first_err_idx;
    logic [W-1:0]  first_err_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_seq_checker #(
        .WIDTH(W), .EXPECT_OUTPUTS(N), .MAX_CYCLES(MAXC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seq_base(seq_base), .seq_step(seq_step),
        .strobe(strobe), .data(data), .busy(busy), .done(done), .pass(pass), .count(count),
        .err_count(err_count), .cycles(cycles), .first_err_idx(first_err_idx),
        .first_err_data(first_err_data), .timeout(timeout), .overrun(overrun)
    );

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] step;
        int           lead;
        int           n;
        logic [15:0]  bad_mask;
        logic         exp_pass;
        logic         exp_tmo;
        logic         exp_ovr;
        int           exp_cnt;
        int           exp_err;
        int           exp_fidx;
        logic [W-1:0] exp_fdata;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[7];

    logic         r_stb[RLEN+1];
    logic [W-1:0] r_dat[RLEN+1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] b, input logic [W-1:0] s);
        start = 1'b1; seq_base = b; seq_step = s; strobe = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        string p;
        p = $sformatf("vec%0d", id);
        do_start(v.base, v.step);
        for (int i = 0; i < v.lead; i++) tick();
        for (int i = 0; i < v.n; i++) begin
            strobe = 1'b1;
            data   = v.bad_mask[i] ? 16'h00AA : W'(v.base + i * v.step);
            tick();
        end
        strobe = 1'b0;
        for (int k = 0; k < 40 && !done; k++) tick();
        chk({p, ".done"},     done, 1);
        chk({p, ".pass"},     pass, v.exp_pass);
        chk({p, ".timeout"},  timeout, v.exp_tmo);
        chk({p, ".overrun"},  overrun, v.exp_ovr);
        chk({p, ".count"},    count, v.exp_cnt);
        chk({p, ".err"},      err_count, v.exp_err);
        chk({p, ".cycles"},   cycles, v.exp_cyc);
        chk({p, ".fidx"},     first_err_idx, v.exp_fidx);
        chk({p, ".fdata"},    first_err_data, v.exp_fdata);
    endtask

    initial begin
        // base step lead n mask pass tmo ovr cnt err fidx fdata cyc
        vecs[0] = '{16'h0000, 16'h0001, 0, 16, 16'h0000, 1, 0, 0, 16, 0, 0, 16'h0000, 16};
        vecs[1] = '{16'h0000, 16'h0001, 0, 16, 16'h0220, 0, 0, 0, 16, 2, 5, 16'h00AA, 16};
        vecs[2] = '{16'hFFFE, 16'h0001, 0, 16, 16'h0000, 1, 0, 0, 16, 0, 0, 16'h0000, 16};
        vecs[3] = '{16'h0000, 16'h0001, 0, 10, 16'h0000, 0, 1, 0, 10, 0, 0, 16'h0000, 20};
        vecs[4] = '{16'h0000, 16'h0001, 4, 16, 16'h0000, 1, 0, 0, 16, 0, 0, 16'h0000, 20};
        vecs[5] = '{16'h0000, 16'h0001, 5, 16, 16'h0000, 0, 1, 1, 15, 0, 0, 16'h0000, 20};
        vecs[6] = '{16'h1234, 16'h0100, 0, 16, 16'h8000, 0, 0, 0, 16, 1, 15, 16'h00AA, 16};

        reset = 1'b1; start = 1'b0; strobe = 1'b0;
        seq_base = '0; seq_step = '0; data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.count", count, 0);
        chk("rst.err", err_count, 0);
        chk("rst.cycles", cycles, 0);
        chk("rst.timeout", timeout, 0);
        chk("rst.overrun", overrun, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Overrun after PASS, then restart clears everything
        run_vec(vecs[0], 100);
        strobe = 1'b1; data = 16'h0010;
        tick();
        strobe = 1'b0;
        chk("ovr.pass", pass, 0);
        chk("ovr.done", done, 1);
        chk("ovr.overrun", overrun, 1);
        chk("ovr.count", count, 16);
        chk("ovr.err", err_count, 0);
        do_start(16'h0000, 16'h0001);
        chk("restart.busy", busy, 1);
        chk("restart.done", done, 0);
        chk("restart.overrun", overrun, 0);
        chk("restart.count", count, 0);
        chk("restart.cycles", cycles, 0);
        chk("restart.timeout", timeout, 0);

        // Reset mid-run at count=7, strobes in IDLE, start with strobe on same edge
        do_start(16'h0000, 16'h0001);
        for (int i = 0; i < 7; i++) begin
            strobe = 1'b1; data = W'(i + 3);
            tick();
        end
        chk("mid.count", count, 7);
        chk("mid.err", err_count, 7);
        reset = 1'b1; start = 1'b1; strobe = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("mrst.busy", busy, 0);
        chk("mrst.count", count, 0);
        chk("mrst.err", err_count, 0);
        chk("mrst.cycles", cycles, 0);
        chk("mrst.fidx", first_err_idx, 0);
        chk("mrst.fdata", first_err_data, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("idle.count", count, 0);
        chk("idle.cycles", cycles, 0);
        chk("idle.busy", busy, 0);
        start = 1'b1; seq_base = 16'h0000; seq_step = 16'h0001; strobe = 1'b1; data = 16'h0000;
        tick();
        start = 1'b0;
        chk("ststb.count", count, 0);
        chk("ststb.busy", busy, 1);
        tick();
        strobe = 1'b0;
        chk("ststb.count1", count, 1);
        chk("ststb.err", err_count, 0);

        // Randomized runs against a position-based reference model
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] b, s;
            int k, cpos, endc, m_cnt, m_err, m_fidx;
            logic [W-1:0] m_fdata;
            logic complete, m_ovr;
            b = W'($urandom);
            s = W'($urandom);
            k = 0;
            for (int j = 1; j <= RLEN; j++) begin
                r_stb[j] = ($urandom_range(0, 99) < 85);
                r_dat[j] = W'(b + k * s);
                if ($urandom_range(0, 99) < 10) r_dat[j] = r_dat[j] ^ W'($urandom_range(1, 16'hFFFF));
                if (r_stb[j]) k++;
            end
            do_start(b, s);
            for (int j = 1; j <= RLEN; j++) begin
                strobe = r_stb[j]; data = r_dat[j];
                tick();
            end
            strobe = 1'b0;

            cpos = 0; k = 0;
            for (int j = 1; j <= RLEN; j++)
                if (r_stb[j]) begin
                    k++;
                    if (k == N && cpos == 0) cpos = j;
                end
            complete = (cpos != 0) && (cpos <= MAXC);
            endc = complete ? cpos : MAXC;
            m_cnt = 0; m_err = 0; m_fidx = 0; m_fdata = '0; m_ovr = 1'b0;
            for (int j = 1; j <= RLEN; j++) begin
                if (r_stb[j] && j <= endc) begin
                    if (r_dat[j] != W'(b + m_cnt * s)) begin
                        if (m_err == 0) begin m_fidx = m_cnt; m_fdata = r_dat[j]; end
                        m_err++;
                    end
                    m_cnt++;
                end else if (r_stb[j]) begin
                    m_ovr = 1'b1;
                end
            end
            chk("rnd.done", done, 1);
            chk("rnd.pass", pass, complete && m_err == 0 && !m_ovr);
            chk("rnd.timeout", timeout, !complete);
            chk("rnd.overrun", overrun, m_ovr);
            chk("rnd.count", count, m_cnt);
            chk("rnd.err", err_count, m_err);
            chk("rnd.cycles", cycles, endc);
            chk("rnd.fidx", first_err_idx, m_fidx);
            chk("rnd.fdata", first_err_data, m_fdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
